axis_oq_admission: RTL

AXIS_OQ_ADMISSION -- requirements
Module: axis_oq_admission

---
 rtl/axis_oq_admission_if.sv | 58 +++++
 rtl/axis_oq_admission.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/axis_oq_admission_if.sv
// rtl/axis_oq_admission_if.sv - ingress/egress/release signal bundle for axis_oq_admission
//
// Signals:
//   s_*        ingress stream: tvalid/tready/tdata/tstrb/tuser/tlast (tuser[15:0] = length in bytes)
//   m_*        egress stream: tvalid/tready/tdata/bytes/qid/tlast
//   rel_*      SRAM read-side release: rel_valid, rel_qid, rel_words
//   drop_count dropped-packet counter
// Modports: master = traffic source/sink around the block, slave = axis_oq_admission.

interface axis_oq_admission_if #(
    parameter int TDATA_BITS  = 256,
    parameter int TUSER_BITS  = 128,
    parameter int NUM_QUEUES  = 5,
    parameter int QUEUE_WORDS = 104857
);
    localparam int BYTES = TDATA_BITS / 8;
    localparam int BW    = $clog2(BYTES) + 1;
    localparam int QID_W = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;
    localparam int CNT_W = $clog2(QUEUE_WORDS + 1);

    logic                  s_tvalid;
    logic                  s_tready;
    logic [TDATA_BITS-1:0] s_tdata;
    logic [BYTES-1:0]      s_tstrb;
    logic [TUSER_BITS-1:0] s_tuser;
    logic                  s_tlast;

    logic                  m_tvalid;
    logic                  m_tready;
    logic [TDATA_BITS-1:0] m_tdata;
    logic [BW-1:0]         m_bytes;
    logic [QID_W-1:0]      m_qid;
    logic                  m_tlast;

    logic                  rel_valid;
    logic [QID_W-1:0]      rel_qid;
    logic [CNT_W-1:0]      rel_words;

    logic [31:0]           drop_count;

    modport master (
        output s_tvalid, s_tdata, s_tstrb, s_tuser, s_tlast,
        input  s_tready,
        input  m_tvalid, m_tdata, m_bytes, m_qid, m_tlast,
        output m_tready,
        output rel_valid, rel_qid, rel_words,
        input  drop_count
    );

    modport slave (
        input  s_tvalid, s_tdata, s_tstrb, s_tuser, s_tlast,
        output s_tready,
        output m_tvalid, m_tdata, m_bytes, m_qid, m_tlast,
        input  m_tready,
        input  rel_valid, rel_qid, rel_words,
        output drop_count
    );
endinterface

// File: rtl/axis_oq_admission.sv
// rtl/axis_oq_admission.sv - output-queue admission control for an AXI-Stream packet ingress
//
// Decodes each packet header (one-hot destination in tuser, byte length in tuser[15:0]),
// admits the packet if its queue has enough free SRAM words, otherwise consumes and drops it.
// Per-queue free-word credits are returned through the rel_* port.
// Ports:
//   clk    clock
//   reset  synchronous, active-high
//   bus    axis_oq_admission_if.slave (s_* ingress, m_* egress, rel_* release, drop_count)
// Build option: OQ_ADMIT_DROP_STATS_EN enables the drop counter; otherwise drop_count reads 0.

module axis_oq_admission #(
    parameter int TDATA_BITS  = 256,
    parameter int TUSER_BITS  = 128,
    parameter int NUM_QUEUES  = 5,
    parameter int QUEUE_WORDS = 104857,
    parameter int DST_POS     = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    axis_oq_admission_if.slave     bus
);
    localparam int BYTES = TDATA_BITS / 8;
    localparam int BW    = $clog2(BYTES) + 1;
    localparam int QID_W = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;
    localparam int CNT_W = $clog2(QUEUE_WORDS + 1);

    typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

    state_t                state;
    logic [CNT_W-1:0]      free     [NUM_QUEUES];
    logic [CNT_W-1:0]      free_nxt [NUM_QUEUES];
    logic [CNT_W:0]        rel_sum  [NUM_QUEUES];
    logic [QID_W-1:0]      cur_qid;

    logic [TUSER_BITS-1:0] user;
    logic [NUM_QUEUES-1:0] dst;
    logic [QID_W-1:0]      hdr_qid;
    logic [31:0]           hdr_words;
    logic                  hdr_admit;
    logic                  can_load;
    logic                  s_ready;
    logic                  accept;
    logic                  load;
    logic                  admit_take;
    logic                  reject_take;
    logic [BW-1:0]         strb_cnt;

    logic                  m_valid_r;
    logic [TDATA_BITS-1:0] m_data_r;
    logic [BW-1:0]         m_bytes_r;
    logic [QID_W-1:0]      m_qid_r;
    logic                  m_last_r;

    assign user = bus.s_tuser;

    always_comb begin
        dst     = user[DST_POS +: NUM_QUEUES];
        // Descending scan so the lowest set bit wins.
        hdr_qid = '0;
        for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
            if (dst[i]) hdr_qid = QID_W'(i);
        end
        hdr_words = (32'(user[15:0]) + 32'(BYTES - 1)) / 32'(BYTES);
        if (hdr_words == 32'd0) hdr_words = 32'd1;
        // Uses the registered (pre-release) credit value.
        hdr_admit = (|dst) && (32'(free[hdr_qid]) >= hdr_words);

        can_load = bus.m_tready | ~m_valid_r;
        case (state)
            IDLE:    s_ready = hdr_admit ? can_load : 1'b1;
            PASS:    s_ready = can_load;
            default: s_ready = 1'b1;
        endcase
        if (reset) s_ready = 1'b0;

        accept      = bus.s_tvalid & s_ready;
        admit_take  = accept & (state == IDLE) & hdr_admit;
        reject_take = accept & (state == IDLE) & ~hdr_admit;
        load        = admit_take | (accept & (state == PASS));

        strb_cnt = '0;
        for (int b = 0; b < BYTES; b++) begin
            strb_cnt = strb_cnt + BW'(bus.s_tstrb[b]);
        end
    end

    // Release saturates first, then the admitted debit is taken; the debit never exceeds
    // the pre-release credit so the subtraction cannot wrap.
    always_comb begin
        for (int i = 0; i < NUM_QUEUES; i++) begin
            rel_sum[i] = {1'b0, free[i]};
            if (bus.rel_valid && bus.rel_qid == QID_W'(i)) begin
                rel_sum[i] = rel_sum[i] + {1'b0, bus.rel_words};
            end
            if (rel_sum[i] > (CNT_W + 1)'(QUEUE_WORDS)) begin
                free_nxt[i] = CNT_W'(QUEUE_WORDS);
            end else begin
                free_nxt[i] = rel_sum[i][CNT_W-1:0];
            end
            if (admit_take && hdr_qid == QID_W'(i)) begin
                free_nxt[i] = free_nxt[i] - hdr_words[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_QUEUES; i++) begin
            if (reset) free[i] <= CNT_W'(QUEUE_WORDS);
            else       free[i] <= free_nxt[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cur_qid   <= '0;
            m_valid_r <= 1'b0;
            m_data_r  <= '0;
            m_bytes_r <= '0;
            m_qid_r   <= '0;
            m_last_r  <= 1'b0;
        end else begin
            if (load) begin
                m_valid_r <= 1'b1;
                m_data_r  <= bus.s_tdata;
                m_last_r  <= bus.s_tlast;
                m_bytes_r <= bus.s_tlast ? strb_cnt : BW'(BYTES);
                m_qid_r   <= (state == IDLE) ? hdr_qid : cur_qid;
            end else if (bus.m_tready) begin
                m_valid_r <= 1'b0;
            end

            if (accept) begin
                case (state)
                    IDLE: begin
                        if (hdr_admit) begin
                            cur_qid <= hdr_qid;
                            state   <= bus.s_tlast ? IDLE : PASS;
                        end else begin
                            state   <= bus.s_tlast ? IDLE : DROP;
                        end
                    end
                    default: begin
                        if (bus.s_tlast) state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef OQ_ADMIT_DROP_STATS_EN
    logic [31:0] drop_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (reject_take && drop_cnt != 32'hFFFF_FFFF) begin
            drop_cnt <= drop_cnt + 32'd1;
        end
    end

    assign bus.drop_count = drop_cnt;
`else
    assign bus.drop_count = 32'd0;
`endif

    assign bus.s_tready = s_ready;
    assign bus.m_tvalid = m_valid_r;
    assign bus.m_tdata  = m_data_r;
    assign bus.m_bytes  = m_bytes_r;
    assign bus.m_qid    = m_qid_r;
    assign bus.m_tlast  = m_last_r;

endmodule
